// File: rtl/pipe_ctrl_pkg.sv
// Shared encodings for the pipeline stall/flush controller.
package pipe_ctrl_pkg;

    localparam int unsigned INST_ADDR_W = 32;
    localparam int unsigned STALL_W     = 6;
    localparam int unsigned WAIT_CNT_W  = 4;
    localparam int unsigned STALL_CNT_W = 32;

    // Per-stage hold values.
    localparam logic STOP    = 1'b1;
    localparam logic NO_STOP = 1'b0;

    localparam logic [INST_ADDR_W-1:0] ZERO_WORD = INST_ADDR_W'(0);

    // Stall patterns, bit0=PC ... bit5=WB.
    localparam logic [STALL_W-1:0] STALL_NONE = 6'b000000;
    localparam logic [STALL_W-1:0] STALL_IF   = 6'b000011;
    localparam logic [STALL_W-1:0] STALL_ID   = 6'b000111;
    localparam logic [STALL_W-1:0] STALL_EX   = 6'b001111;
    localparam logic [STALL_W-1:0] STALL_MEM  = 6'b011111;

    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_MEM_BUSY = 2'd1,
        ST_MEM_DONE = 2'd2,
        ST_FLUSH    = 2'd3
    } state_e;

endpackage

// File: rtl/pipe_ctrl_stall_prio_enc.sv
// Priority encoder turning per-stage hold requests into a stall pattern.
module stall_prio_enc
    import pipe_ctrl_pkg::*;
(
    input  logic               stallreq_if,
    input  logic               stallreq_id,
    input  logic               stallreq_ex,
    input  logic               stallreq_mem,
    output logic [STALL_W-1:0] stall_c
);

    // The deepest requesting stage wins; it holds itself and everything upstream.
    always_comb begin
        stall_c = STALL_NONE;
        if (stallreq_mem) begin
            stall_c = STALL_MEM;
        end else if (stallreq_ex) begin
            stall_c = STALL_EX;
        end else if (stallreq_id) begin
            stall_c = STALL_ID;
        end else if (stallreq_if) begin
            stall_c = STALL_IF;
        end
    end

endmodule

// File: rtl/pipe_ctrl.sv
// Pipeline controller: base-RAM arbitration between IF and MEM, stall
// generation, flush/redirect, and a saturating stall-cycle counter.
module pipe_ctrl
    import pipe_ctrl_pkg::*;
#(
    parameter int unsigned WAIT_CYCLES = 2
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   stallreq_if,
    input  logic                   stallreq_id,
    input  logic                   stallreq_ex,
    input  logic                   stallreq_mem,
    input  logic                   mem_ram_req,
    input  logic                   flush_req,
    input  logic [INST_ADDR_W-1:0] new_pc_i,
    output logic [STALL_W-1:0]     stall,
    output logic                   flush,
    output logic [INST_ADDR_W-1:0] new_pc_o,
    output logic                   ram_owner,
    output logic                   mem_done,
    output logic [STALL_CNT_W-1:0] stall_cycles
);

    // The accept cycle is the first of the WAIT_CYCLES, so the counter starts one lower.
    localparam logic [WAIT_CNT_W-1:0] WAIT_LOAD = WAIT_CNT_W'(WAIT_CYCLES - 1);
    localparam logic [STALL_CNT_W-1:0] STALL_CNT_MAX = '1;

    state_e                 state_q, state_d;
    logic [WAIT_CNT_W-1:0]  cnt_q, cnt_d;
    logic [INST_ADDR_W-1:0] new_pc_q, new_pc_d;
    logic [STALL_CNT_W-1:0] stall_cycles_q, stall_cycles_d;
    logic [STALL_W-1:0]     fsm_stall;
    logic [STALL_W-1:0]     req_stall_c;

    stall_prio_enc u_stall_prio_enc (
        .stallreq_if  (stallreq_if),
        .stallreq_id  (stallreq_id),
        .stallreq_ex  (stallreq_ex),
        .stallreq_mem (stallreq_mem),
        .stall_c      (req_stall_c)
    );

    // Next-state, wait counter, redirect capture and state-derived outputs.
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        new_pc_d  = new_pc_q;
        fsm_stall = STALL_NONE;
        ram_owner = 1'b0;
        mem_done  = 1'b0;
        flush     = 1'b0;

        unique case (state_q)
            ST_IDLE: begin
                if (mem_ram_req && !flush_req) begin
                    ram_owner = 1'b1;
                    fsm_stall = STALL_MEM;
                    cnt_d     = WAIT_LOAD;
                    state_d   = (WAIT_CYCLES == 1) ? ST_MEM_DONE : ST_MEM_BUSY;
                end
            end
            ST_MEM_BUSY: begin
                ram_owner = 1'b1;
                fsm_stall = STALL_MEM;
                cnt_d     = cnt_q - WAIT_CNT_W'(1);
                if (cnt_q <= WAIT_CNT_W'(1)) begin
                    state_d = ST_MEM_DONE;
                end
            end
            ST_MEM_DONE: begin
                // A flush arriving now aborts the access, so no completion pulse.
                ram_owner = 1'b1;
                mem_done  = !flush_req;
                fsm_stall = STALL_IF;
                state_d   = ST_IDLE;
            end
            ST_FLUSH: begin
                flush   = 1'b1;
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        // Redirect overrides everything, including an in-flight RAM access.
        if (flush_req) begin
            state_d  = ST_FLUSH;
            new_pc_d = new_pc_i;
            cnt_d    = '0;
        end
    end

    // Combine FSM holds with stage requests; a flush cycle releases every stage.
    always_comb begin
        stall = (state_q == ST_FLUSH) ? STALL_NONE : (fsm_stall | req_stall_c);
    end

    // Saturating count of cycles with the PC held.
    always_comb begin
        stall_cycles_d = stall_cycles_q;
        if ((stall[0] == STOP) && (stall_cycles_q != STALL_CNT_MAX)) begin
            stall_cycles_d = stall_cycles_q + STALL_CNT_W'(1);
        end
    end

    // State and counters, synchronous active-high reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q        <= ST_IDLE;
            cnt_q          <= '0;
            new_pc_q       <= ZERO_WORD;
            stall_cycles_q <= '0;
        end else begin
            state_q        <= state_d;
            cnt_q          <= cnt_d;
            new_pc_q       <= new_pc_d;
            stall_cycles_q <= stall_cycles_d;
        end
    end

    assign new_pc_o     = new_pc_q;
    assign stall_cycles = stall_cycles_q;

endmodule

// File: tb/tb_pipe_ctrl.sv
// Scoreboard bench for pipe_ctrl: three instances (WAIT_CYCLES 1, 2, 4)
// share stimulus; a queue-based reference model predicts every cycle.
module tb_pipe_ctrl;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        s_if = 1'b0, s_id = 1'b0, s_ex = 1'b0, s_mem = 1'b0;
    logic        mreq = 1'b0, freq = 1'b0;
    logic [31:0] pc_i = 32'h0;

    logic [5:0]  stall_o [3];
    logic        flush_o [3];
    logic [31:0] pc_o    [3];
    logic        owner_o [3];
    logic        done_o  [3];
    logic [31:0] cnt_o   [3];

    always #5 clk = ~clk;

    pipe_ctrl #(.WAIT_CYCLES(1)) dut_w1 (
        .clk(clk), .rst(rst), .stallreq_if(s_if), .stallreq_id(s_id),
        .stallreq_ex(s_ex), .stallreq_mem(s_mem), .mem_ram_req(mreq),
        .flush_req(freq), .new_pc_i(pc_i), .stall(stall_o[0]), .flush(flush_o[0]),
        .new_pc_o(pc_o[0]), .ram_owner(owner_o[0]), .mem_done(done_o[0]),
        .stall_cycles(cnt_o[0]));

    pipe_ctrl #(.WAIT_CYCLES(2)) dut_w2 (
        .clk(clk), .rst(rst), .stallreq_if(s_if), .stallreq_id(s_id),
        .stallreq_ex(s_ex), .stallreq_mem(s_mem), .mem_ram_req(mreq),
        .flush_req(freq), .new_pc_i(pc_i), .stall(stall_o[1]), .flush(flush_o[1]),
        .new_pc_o(pc_o[1]), .ram_owner(owner_o[1]), .mem_done(done_o[1]),
        .stall_cycles(cnt_o[1]));

    pipe_ctrl #(.WAIT_CYCLES(4)) dut_w4 (
        .clk(clk), .rst(rst), .stallreq_if(s_if), .stallreq_id(s_id),
        .stallreq_ex(s_ex), .stallreq_mem(s_mem), .mem_ram_req(mreq),
        .flush_req(freq), .new_pc_i(pc_i), .stall(stall_o[2]), .flush(flush_o[2]),
        .new_pc_o(pc_o[2]), .ram_owner(owner_o[2]), .mem_done(done_o[2]),
        .stall_cycles(cnt_o[2]));

    typedef struct packed {
        logic [5:0]  stall;
        logic        flush;
        logic [31:0] pc;
        logic        owner;
        logic        done;
        logic [31:0] cnt;
    } exp_t;

    exp_t q0[$];
    exp_t q1[$];
    exp_t q2[$];

    int checks = 0;
    int passed = 0;
    int cyc    = 0;

    // Reference model: an access is "accept + N busy cycles + one done cycle".
    int          wv       [3] = '{1, 2, 4};
    int          busy_left[3];
    bit          m_done   [3];
    bit          m_flush  [3];
    logic [31:0] m_pc     [3];
    logic [31:0] m_cnt    [3];
    bit          m_known = 1'b0;

    function automatic logic [5:0] req_pattern();
        if (s_mem) return 6'b011111;
        if (s_ex)  return 6'b001111;
        if (s_id)  return 6'b000111;
        if (s_if)  return 6'b000011;
        return 6'b000000;
    endfunction

    function automatic void model_step(input int k, output exp_t e);
        logic [5:0] hold;
        hold    = 6'b000000;
        e       = '0;
        e.pc    = m_pc[k];
        e.cnt   = m_cnt[k];
        if (m_flush[k]) begin
            e.flush = 1'b1;
        end else if (m_done[k]) begin
            e.owner = 1'b1;
            e.done  = !freq;
            hold    = 6'b000011;
        end else if (busy_left[k] > 0 || (mreq && !freq)) begin
            e.owner = 1'b1;
            hold    = 6'b011111;
        end
        e.stall = m_flush[k] ? 6'b000000 : (hold | req_pattern());

        if (rst) begin
            busy_left[k] = 0;
            m_done[k]    = 1'b0;
            m_flush[k]   = 1'b0;
            m_pc[k]      = 32'h0;
            m_cnt[k]     = 32'h0;
        end else begin
            if (e.stall[0] && m_cnt[k] != 32'hFFFFFFFF) m_cnt[k] = m_cnt[k] + 32'd1;
            if (freq) begin
                m_flush[k]   = 1'b1;
                m_pc[k]      = pc_i;
                busy_left[k] = 0;
                m_done[k]    = 1'b0;
            end else if (m_flush[k]) begin
                m_flush[k] = 1'b0;
            end else if (m_done[k]) begin
                m_done[k] = 1'b0;
            end else if (busy_left[k] > 0) begin
                busy_left[k] = busy_left[k] - 1;
                m_done[k]    = (busy_left[k] == 0);
            end else if (mreq) begin
                busy_left[k] = wv[k] - 1;
                m_done[k]    = (busy_left[k] == 0);
            end
        end
    endfunction

    // Apply one cycle of inputs just after the edge and queue the expected outputs.
    task automatic drive(input bit r, input bit sif, input bit sid, input bit sex,
                         input bit smem, input bit mr, input bit fr, input logic [31:0] pc);
        exp_t e;
        @(posedge clk);
        #1;
        rst = r; s_if = sif; s_id = sid; s_ex = sex; s_mem = smem;
        mreq = mr; freq = fr; pc_i = pc;
        cyc++;
        for (int k = 0; k < 3; k++) begin
            model_step(k, e);
            if (m_known) begin
                if (k == 0) q0.push_back(e);
                else if (k == 1) q1.push_back(e);
                else q2.push_back(e);
            end
        end
        if (r) m_known = 1'b1;
    endtask

    // Overwrite the stall counters so saturation is reachable quickly.
    task automatic preload_counters();
        @(posedge clk);
        #1;
        force dut_w1.stall_cycles_q = 32'hFFFFFFFE;
        force dut_w2.stall_cycles_q = 32'hFFFFFFFE;
        force dut_w4.stall_cycles_q = 32'hFFFFFFFE;
        #1;
        release dut_w1.stall_cycles_q;
        release dut_w2.stall_cycles_q;
        release dut_w4.stall_cycles_q;
        for (int k = 0; k < 3; k++) m_cnt[k] = 32'hFFFFFFFE;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) drive(0, 0, 0, 0, 0, 0, 0, 32'h0);
    endtask

    task automatic check_out(input int k, input exp_t e, input exp_t a);
        checks++;
        if (a === e) begin
            passed++;
        end else begin
            $display("FAIL outputs_w%0d cycle %0d: got stall=%b flush=%b pc=%h owner=%b done=%b cnt=%h, expected stall=%b flush=%b pc=%h owner=%b done=%b cnt=%h",
                     wv[k], cyc, a.stall, a.flush, a.pc, a.owner, a.done, a.cnt,
                     e.stall, e.flush, e.pc, e.owner, e.done, e.cnt);
        end
    endtask

    task automatic expect_val(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act === exp) passed++;
        else $display("FAIL %s cycle %0d: got %h, expected %h", name, cyc, act, exp);
    endtask

    function automatic exp_t actual(input int k);
        exp_t a;
        a.stall = stall_o[k];
        a.flush = flush_o[k];
        a.pc    = pc_o[k];
        a.owner = owner_o[k];
        a.done  = done_o[k];
        a.cnt   = cnt_o[k];
        return a;
    endfunction

    // Monitor: mid-cycle, pop and compare whatever each instance presents.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (q0.size() > 0) begin e = q0.pop_front(); check_out(0, e, actual(0)); end
            if (q1.size() > 0) begin e = q1.pop_front(); check_out(1, e, actual(1)); end
            if (q2.size() > 0) begin e = q2.pop_front(); check_out(2, e, actual(2)); end
        end
    end

    logic [5:0] exp_w2_stall [4];
    logic       exp_w2_done  [4];
    logic       exp_w2_owner [4];

    initial begin
        exp_w2_stall = '{6'b011111, 6'b011111, 6'b000011, 6'b000000};
        exp_w2_done  = '{1'b0, 1'b0, 1'b1, 1'b0};
        exp_w2_owner = '{1'b1, 1'b1, 1'b1, 1'b0};

        drive(1, 0, 0, 0, 0, 0, 0, 32'h0);
        drive(1, 0, 0, 0, 0, 0, 0, 32'h0);
        idle(2);

        // Single RAM access on the WAIT_CYCLES=2 instance.
        drive(0, 0, 0, 0, 0, 1, 0, 32'h0);
        for (int i = 0; i < 4; i++) begin
            if (i > 0) drive(0, 0, 0, 0, 0, 0, 0, 32'h0);
            @(negedge clk);
            #1;
            expect_val("w2_access_stall", 32'(stall_o[1]), 32'(exp_w2_stall[i]));
            expect_val("w2_access_done", 32'(done_o[1]), 32'(exp_w2_done[i]));
            expect_val("w2_access_owner", 32'(owner_o[1]), 32'(exp_w2_owner[i]));
        end
        idle(3);

        // Request priority: ID+EX, then MEM added.
        drive(0, 0, 1, 1, 0, 0, 0, 32'h0);
        drive(0, 0, 1, 1, 0, 0, 0, 32'h0);
        drive(0, 0, 1, 1, 1, 0, 0, 32'h0);
        drive(0, 1, 1, 1, 1, 0, 0, 32'h0);
        drive(0, 1, 0, 0, 0, 0, 0, 32'h0);
        idle(2);

        // Flush in the second busy cycle of the WAIT_CYCLES=4 instance.
        drive(0, 0, 0, 0, 0, 1, 0, 32'h0);
        drive(0, 0, 0, 0, 0, 0, 0, 32'h0);
        drive(0, 0, 0, 0, 0, 0, 1, 32'hBFC00380);
        drive(0, 0, 0, 0, 0, 0, 0, 32'h0);
        @(negedge clk);
        #1;
        expect_val("flush_w4_flush", 32'(flush_o[2]), 32'd1);
        expect_val("flush_w4_new_pc", pc_o[2], 32'hBFC00380);
        expect_val("flush_w4_stall", 32'(stall_o[2]), 32'd0);
        expect_val("flush_w4_owner", 32'(owner_o[2]), 32'd0);
        idle(6);

        // Back-to-back flush requests, then a request held through WAIT_CYCLES=1 accesses.
        drive(0, 0, 0, 0, 0, 1, 1, 32'h00001000);
        drive(0, 0, 0, 0, 0, 1, 1, 32'h00002000);
        idle(2);
        for (int i = 0; i < 8; i++) drive(0, 0, 0, 0, 0, 1, 0, 32'h0);
        idle(5);

        // Reset in the middle of a WAIT_CYCLES=4 access.
        drive(0, 0, 0, 0, 0, 1, 0, 32'h0);
        drive(1, 0, 0, 0, 0, 0, 0, 32'h0);
        drive(0, 0, 0, 0, 0, 0, 0, 32'h0);
        @(negedge clk);
        #1;
        expect_val("rst_w4_stall", 32'(stall_o[2]), 32'd0);
        expect_val("rst_w4_owner", 32'(owner_o[2]), 32'd0);
        expect_val("rst_w4_done", 32'(done_o[2]), 32'd0);
        expect_val("rst_w4_cnt", cnt_o[2], 32'd0);
        idle(4);

        // Counter saturation from a preloaded value.
        preload_counters();
        rst = 1'b0; s_if = 1'b1; s_id = 1'b0; s_ex = 1'b0; s_mem = 1'b0;
        mreq = 1'b0; freq = 1'b0; pc_i = 32'h0;
        cyc++;
        for (int k = 0; k < 3; k++) begin
            exp_t e;
            model_step(k, e);
            if (k == 0) q0.push_back(e);
            else if (k == 1) q1.push_back(e);
            else q2.push_back(e);
        end
        drive(0, 1, 0, 0, 0, 0, 0, 32'h0);
        drive(0, 1, 0, 0, 0, 0, 0, 32'h0);
        drive(0, 0, 0, 0, 0, 0, 0, 32'h0);
        @(negedge clk);
        #1;
        expect_val("sat_w1_cnt", cnt_o[0], 32'hFFFFFFFF);
        expect_val("sat_w4_cnt", cnt_o[2], 32'hFFFFFFFF);
        drive(1, 0, 0, 0, 0, 0, 0, 32'h0);
        idle(2);

        // Randomized traffic.
        for (int i = 0; i < 400; i++) begin
            drive(($urandom_range(99) < 2), ($urandom_range(99) < 20), ($urandom_range(99) < 15),
                  ($urandom_range(99) < 10), ($urandom_range(99) < 8), ($urandom_range(99) < 35),
                  ($urandom_range(99) < 7), $urandom);
        end
        idle(2);

        @(posedge clk);
        @(negedge clk);
        #1;
        checks++;
        if (q0.size() == 0 && q1.size() == 0 && q2.size() == 0) passed++;
        else $display("FAIL scoreboard_drain: got %0d/%0d/%0d left, expected 0/0/0",
                      q0.size(), q1.size(), q2.size());

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
